digit_serial_adder: RTL and testbench
=====================================

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter S, default 8: operand and result width in bits.
REQ-002 Parameter D, default 2: digit width processed per clock; S SHALL be an integer multiple of D, and elaboration SHALL fail otherwise.
REQ-003 Derived constant N = S/D: number of digit cycles per operation.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-007 sub  input  1  mode select: 0 = a+b, 1 = a-b; sampled with start.
REQ-008 a  input  S  first operand; sampled with start.
REQ-009 b  input  S  second operand; sampled with start.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  single-cycle pulse, high in DONE.
REQ-012 s  output  S  registered result.
REQ-013 carry_out  output  1  registered carry out of the MSB digit (for sub: 1 = no borrow).
REQ-014 overflow  output  1  registered two's-complement signed overflow.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 Transition IDLE -> RUN on an edge with start=1.
- Latch a into the A register.
- Latch (sub ? ~b : b) into the B register.
- Carry register <= sub.
- Digit index <= 0.
REQ-017 Each RUN edge processes one digit, i = index:
- Add A[i*D+D-1 : i*D] + B[same bits] + carry.
- Write the D-bit sum into the partial-result register at the same bit position.
- Carry <= digit carry out; index <= index+1.
REQ-018 On the RUN edge with index = N-1:
- After the final digit, transfer the full partial result to s, the final carry to carry_out, and the overflow flag to overflow.
- State <= DONE.
REQ-019 overflow SHALL be 1 iff A[S-1] = B[S-1] (after inversion) and s[S-1] differs from them.
REQ-020 DONE lasts one cycle.
- On start=1, DONE -> RUN with a fresh latch as in REQ-016 (back-to-back operation).
- Otherwise DONE -> IDLE.
REQ-021 Latency: start sampled at edge k gives done=1 in the cycle following edge k+N, so one result per N+1 cycles with back-to-back starts.
REQ-022 start in RUN SHALL be ignored; operands and mode of the operation in flight SHALL be unaffected.
REQ-023 a, b and sub changes outside the start-sampling edge SHALL have no effect.
REQ-024 s, carry_out and overflow SHALL hold their last values from completion until the next completion.
REQ-025 With N = 1 (D = S), the block SHALL complete in a single RUN cycle, behaving as a registered full-width adder.
REQ-026 Index register width SHALL be max(1, clog2(N)); it SHALL never exceed N-1.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for a clock edge, force:
- State to IDLE.
- busy=0, done=0, s=0, carry_out=0, overflow=0.
- Index, carry and the A, B and partial-result registers to 0.
REQ-028 Reset during RUN SHALL abandon the operation; no done pulse SHALL follow, and the outputs SHALL read 0.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-030 The state enum (IDLE, RUN, DONE) SHALL reside in shared package adder_pkg.
REQ-031 The per-digit carry-in/carry-out adder SHALL be sub-module digit_adder, parameterised by D: inputs x[D], y[D], cin; outputs sum[D], cout.
REQ-032 The datapath SHALL contain exactly one digit_adder instance, time-multiplexed across digits; no S-bit carry chain.

Verification (S=8, D=2, N=4 unless stated)
REQ-033 Signed-overflow add: a=0x7F, b=0x01, sub=0, start pulse -> done 5 cycles after start edge, s=0x80, carry_out=0, overflow=1.
REQ-034 Unsigned-wrap add: a=0xFF, b=0x01, sub=0 -> s=0x00, carry_out=1, overflow=0.
REQ-035 Subtraction with borrow: a=0x05, b=0x07, sub=1 -> s=0xFE, carry_out=0, overflow=0; then a=0x80, b=0x01, sub=1 -> s=0x7F, overflow=1.
REQ-036 start asserted in RUN cycles 2-3 with different operands -> ignored; first result correct; exactly one done pulse.
REQ-037 Back-to-back and reset:
- Start held high through DONE -> second operation begins and its done follows 5 cycles later.
- rst pulse mid-RUN -> all outputs 0 asynchronously and no done pulse.
REQ-038 Parameter sweep (S=8, D=8) and (S=16, D=4): 200 random operands/modes each -> s, carry_out and overflow match a golden model; latency = N+1 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package adder_pkg;

  // Control states of the digit-serial adder.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1. Never narrower than one bit,
  // so an N=1 build still has a legal index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// D-bit ripple adder with carry in and carry out; the single arithmetic
// element that the serial datapath reuses for every digit.
module digit_adder #(
  parameter int D = 2
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout
);

  // Zero-extend all three terms so the extra top bit captures the carry.
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{D{1'b0}}, cin};

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes D bits per clock using a single
// digit_adder, finishing an S-bit operation in N = S/D RUN cycles.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int S = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [S-1:0] s,
  output logic         carry_out,
  output logic         overflow
);

  localparam int N  = S / D;
  localparam int IW = idx_width(N);

  // Refuse to build when the operand width cannot be split into whole digits.
  generate
    if ((D < 1) || ((S % D) != 0)) begin : g_bad_digit_width
      $error("digit_serial_adder: S must be a positive multiple of D");
    end
  endgenerate

  state_t        state_reg;
  logic [S-1:0]  a_reg;
  logic [S-1:0]  b_reg;       // holds b, or ~b for subtraction
  logic [S-1:0]  part_reg;    // digits produced so far
  logic          carry_reg;   // carry into the current digit
  logic [IW-1:0] idx_reg;     // digit currently being processed

  logic [31:0]   digit_base;
  logic [D-1:0]  x_digit;
  logic [D-1:0]  y_digit;
  logic [D-1:0]  sum_digit;
  logic          cout_digit;
  logic [S-1:0]  part_next;
  logic          last_digit;
  logic          overflow_next;

  assign digit_base = 32'(idx_reg) * 32'(D);
  assign last_digit = (idx_reg == IW'(N - 1));

  // Select the operand digits addressed by the index register.
  always_comb begin
    x_digit = a_reg[digit_base +: D];
    y_digit = b_reg[digit_base +: D];
  end

  digit_adder #(
    .D(D)
  ) u_digit_adder (
    .x    (x_digit),
    .y    (y_digit),
    .cin  (carry_reg),
    .sum  (sum_digit),
    .cout (cout_digit)
  );

  // Partial result with this cycle's digit merged in; on the last digit this
  // is the complete sum, so it can be published in the same edge.
  always_comb begin
    part_next = part_reg;
    part_next[digit_base +: D] = sum_digit;
  end

  // Signed overflow: both addends share a sign and the result sign differs.
  assign overflow_next = (a_reg[S-1] == b_reg[S-1]) && (part_next[S-1] != a_reg[S-1]);

  // Control FSM and datapath registers, with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      part_reg  <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            idx_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RUN: begin
          part_reg  <= part_next;
          carry_reg <= cout_digit;
          if (last_digit) begin
            s         <= part_next;
            carry_out <= cout_digit;
            overflow  <= overflow_next;
            idx_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three builds (S/D = 8/2, 8/8, 16/4) share one
// clock and reset. Each build has an arithmetic reference model that is
// compared against the outputs on every clock; the 8/2 build also gets
// directed operations with literal expectations.
module tb_digit_serial_adder;

  function automatic int cfg_s(input int k);
    case (k)
      0:       return 8;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_d(input int k);
    case (k)
      0:       return 2;
      1:       return 8;
      default: return 4;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic        sub_v   [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic [15:0] s_w     [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        co_w    [3];
  logic        ov_w    [3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int SG = cfg_s(gi);
      localparam int DG = cfg_d(gi);
      localparam int NG = SG / DG;

      logic [SG-1:0] s_loc;
      logic          busy_loc, done_loc, co_loc, ov_loc;

      digit_serial_adder #(
        .S(SG),
        .D(DG)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start_v[gi]),
        .sub       (sub_v[gi]),
        .a         (a_v[gi][SG-1:0]),
        .b         (b_v[gi][SG-1:0]),
        .busy      (busy_loc),
        .done      (done_loc),
        .s         (s_loc),
        .carry_out (co_loc),
        .overflow  (ov_loc)
      );

      assign s_w[gi]    = 16'(s_loc);
      assign busy_w[gi] = busy_loc;
      assign done_w[gi] = done_loc;
      assign co_w[gi]   = co_loc;
      assign ov_w[gi]   = ov_loc;

      // Reference: an accepted start yields the arithmetic result N edges
      // later; rem counts the RUN edges still outstanding.
      int            rem   = 0;
      logic [SG-1:0] p_s   = '0;
      logic          p_co  = 1'b0;
      logic          p_ov  = 1'b0;
      logic [SG-1:0] e_s   = '0;
      logic          e_co  = 1'b0;
      logic          e_ov  = 1'b0;
      logic          e_done = 1'b0;

      always @(posedge clk) begin : model
        longint rng, half, ua, ub, sa, sb, r, sr;
        if (rst) begin
          rem = 0; e_s = '0; e_co = 1'b0; e_ov = 1'b0; e_done = 1'b0;
        end else if (rem > 0) begin
          rem--;
          e_done = 1'b0;
          if (rem == 0) begin
            e_done = 1'b1; e_s = p_s; e_co = p_co; e_ov = p_ov;
          end
        end else begin
          e_done = 1'b0;
          if (start_v[gi]) begin
            rng  = longint'(1) << SG;
            half = rng >> 1;
            ua   = longint'(a_v[gi]) & (rng - 1);
            ub   = longint'(b_v[gi]) & (rng - 1);
            sa   = (ua >= half) ? ua - rng : ua;
            sb   = (ub >= half) ? ub - rng : ub;
            if (sub_v[gi]) begin
              r = ua - ub; p_co = (ua >= ub); sr = sa - sb;
            end else begin
              r = ua + ub; p_co = (r >= rng); sr = sa + sb;
            end
            p_s  = r[SG-1:0];
            p_ov = (sr >= half) || (sr < -half);
            rem  = NG;
          end
        end
        #1;
        check($sformatf("cfg%0d_busy", gi), longint'(busy_loc), longint'(rem > 0));
        check($sformatf("cfg%0d_done", gi), longint'(done_loc), longint'(e_done));
        check($sformatf("cfg%0d_s", gi), longint'(s_loc), longint'(e_s));
        check($sformatf("cfg%0d_carry_out", gi), longint'(co_loc), longint'(e_co));
        check($sformatf("cfg%0d_overflow", gi), longint'(ov_loc), longint'(e_ov));
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done on build k, counting edges after the start edge.
  task automatic wait_done(input int k, input bit scramble, output int lat);
    lat = 0;
    do begin
      if (scramble) begin
        a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); sub_v[k] = 1'($urandom);
      end
      tick();
      lat++;
    end while (!done_w[k] && lat < 40);
    check($sformatf("cfg%0d_done_seen", k), longint'(done_w[k]), 1);
  endtask

  // Directed operation on the 8/2 build with literal expectations.
  task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    a_v[0] = 16'(av); b_v[0] = 16'(bv); sub_v[0] = sv; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_done(0, 1'b0, lat);
    check({name, "_latency"}, lat, 4);
    check({name, "_s"}, s_w[0], es);
    check({name, "_carry_out"}, co_w[0], ec);
    check({name, "_overflow"}, ov_w[0], eo);
    $display("op %s: a=%02h b=%02h sub=%0d -> s=%02h c=%0d v=%0d latency=%0d",
             name, av, bv, sv, s_w[0], co_w[0], ov_w[0], lat);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, nd, gap;
    logic [15:0] cap_s;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; sub_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    rst = 1'b1;
    repeat (3) tick();
    check("reset_busy", busy_w[0], 0);
    check("reset_done", done_w[0], 0);
    check("reset_s", s_w[0], 0);
    check("reset_carry_out", co_w[0], 0);
    check("reset_overflow", ov_w[0], 0);
    rst = 1'b0;
    tick();

    run_op("signed_ovf_add", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("unsigned_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    tick();

    // start raised again during RUN with other operands must be ignored.
    a_v[0] = 16'h12; b_v[0] = 16'h34; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    a_v[0] = 16'hAA; b_v[0] = 16'h55; sub_v[0] = 1'b1; start_v[0] = 1'b1;
    tick();
    tick();
    start_v[0] = 1'b0;
    nd = 0; cap_s = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_w[0]) begin nd++; cap_s = s_w[0]; end
    end
    check("ignore_start_done_count", nd, 1);
    check("ignore_start_s", cap_s, 16'h46);
    $display("op ignore_start: done pulses=%0d s=%02h", nd, cap_s);

    // Back-to-back: start held high through DONE.
    a_v[0] = 16'h40; b_v[0] = 16'h40; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    tick();
    a_v[0] = 16'hC0; b_v[0] = 16'h50;
    wait_done(0, 1'b0, lat);
    check("b2b_first_latency", lat, 4);
    check("b2b_first_s", s_w[0], 16'h80);
    check("b2b_first_overflow", ov_w[0], 1);
    tick();
    start_v[0] = 1'b0;
    gap = 1;
    while (!done_w[0] && gap < 40) begin tick(); gap++; end
    check("b2b_gap", gap, 5);
    check("b2b_second_s", s_w[0], 16'h10);
    check("b2b_second_carry_out", co_w[0], 1);
    check("b2b_second_overflow", ov_w[0], 0);
    $display("op back_to_back: gap=%0d s=%02h c=%0d v=%0d", gap, s_w[0], co_w[0], ov_w[0]);

    // Reset mid-RUN: outputs clear without a clock edge, no done follows.
    tick();
    a_v[0] = 16'h55; b_v[0] = 16'h22; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy_w[0], 0);
    check("async_rst_done", done_w[0], 0);
    check("async_rst_s", s_w[0], 0);
    check("async_rst_carry_out", co_w[0], 0);
    check("async_rst_overflow", ov_w[0], 0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_w[0]) nd++;
    end
    check("rst_no_done", nd, 0);
    $display("op reset_mid_run: done pulses after reset=%0d", nd);
    run_op("after_reset", 8'h33, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0);

    // Random sweep on the 8/8 and 16/4 builds; inputs scrambled while busy.
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 200; i++) begin
        a_v[k] = 16'($urandom); b_v[k] = 16'($urandom);
        sub_v[k] = 1'($urandom); start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        wait_done(k, 1'b1, lat);
        check($sformatf("cfg%0d_latency", k), lat, cfg_s(k) / cfg_d(k));
        $display("op cfg%0d #%0d: s=%0h c=%0d v=%0d latency=%0d",
                 k, i, s_w[k], co_w[k], ov_w[k], lat);
      end
      tick();
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
